div_unit: RTL and testbench

- Multicycle restoring shift-subtract divider for the MIPS datapath; responder side of the control unit's divide handshake.
- Control unit pulses start (its DivControl) with operands from registers A/B.
- Block returns done/div_zero (control's Divisor status input) and drives quotient/remainder toward the Lo/Hi registers.
- Implements DIV (signed) and DIVU (unsigned).

---
 rtl/div_unit_if.sv | 25 ++
 rtl/div_unit.sv | 120 ++++++++++++
 tb/tb_div_unit.sv | 212 +++++++++++++++++++++
 3 files changed

// File: rtl/div_unit_if.sv
// Divide handshake between the control unit (master) and the divider (slave).
// Carries operands and mode toward the divider, and results plus status back.
interface div_unit_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic             sign_mode;
  logic [WIDTH-1:0] dividend;
  logic [WIDTH-1:0] divisor;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;
  logic             busy;
  logic             done;
  logic             div_zero;

  modport master (
    output start, sign_mode, dividend, divisor,
    input  hi, lo, busy, done, div_zero
  );

  modport slave (
    input  start, sign_mode, dividend, divisor,
    output hi, lo, busy, done, div_zero
  );
endinterface

// File: rtl/div_unit.sv
// Multicycle restoring shift-subtract divider for DIV/DIVU. The quotient goes to
// lo and the remainder to hi; done is a one-cycle pulse and div_zero flags x/0.
//
// state  | meaning
// IDLE   | waiting for start; operands sampled on the accepting edge
// RUN    | one quotient bit per cycle, WIDTH cycles
// FIX    | apply result signs and write hi/lo
// DONE   | done pulse is registered out on the following edge
module div_unit #(
  parameter int WIDTH = 32
) (
  input logic       clock,
  input logic       reset_n,
  div_unit_if.slave bus
);
  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_FIX, S_DONE} state_t;

  state_t           r_state, w_next;
  logic [CW-1:0]    r_cnt;
  logic [WIDTH-1:0] r_rem, r_quo, r_dvs, r_hi, r_lo;
  logic             r_qneg, r_rneg, r_zero;
  logic             r_busy, r_done, r_div_zero;

  logic             w_accept, w_iter, w_fix;
  logic [WIDTH-1:0] w_dvd_mag, w_dvs_mag, w_diff;
  logic [WIDTH:0]   w_shift;
  logic             w_ge, w_dvs_zero;

  assign w_dvs_zero = (bus.divisor == '0);
  assign w_dvd_mag  = (bus.sign_mode && bus.dividend[WIDTH-1]) ? -bus.dividend : bus.dividend;
  assign w_dvs_mag  = (bus.sign_mode && bus.divisor[WIDTH-1])  ? -bus.divisor  : bus.divisor;

  // Shifted partial remainder can need WIDTH+1 bits; the compare uses all of them.
  assign w_shift = {r_rem, r_quo[WIDTH-1]};
  assign w_ge    = (w_shift >= {1'b0, r_dvs});
  assign w_diff  = w_shift[WIDTH-1:0] - r_dvs;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) r_state <= S_IDLE;
    else          r_state <= w_next;
  end

  // r_done blocks re-acceptance so a held start waits until done has fallen.
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: if (bus.start && !r_done) w_next = w_dvs_zero ? S_DONE : S_RUN;
      S_RUN:  if (r_cnt == '0) w_next = S_FIX;
      S_FIX:  w_next = S_DONE;
      S_DONE: w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_comb begin
    w_accept = 1'b0;
    w_iter   = 1'b0;
    w_fix    = 1'b0;
    case (r_state)
      S_IDLE:  w_accept = bus.start && !r_done;
      S_RUN:   w_iter   = 1'b1;
      S_FIX:   w_fix    = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_cnt      <= '0;
      r_rem      <= '0;
      r_quo      <= '0;
      r_dvs      <= '0;
      r_hi       <= '0;
      r_lo       <= '0;
      r_qneg     <= 1'b0;
      r_rneg     <= 1'b0;
      r_zero     <= 1'b0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_div_zero <= 1'b0;
    end else begin
      r_done <= (r_state == S_DONE);
      if (r_done) r_busy <= 1'b0;
      if (r_state == S_DONE && r_zero) r_div_zero <= 1'b1;

      if (w_accept) begin
        r_busy <= 1'b1;
        r_zero <= w_dvs_zero;
        if (!w_dvs_zero) begin
          r_rem      <= '0;
          r_quo      <= w_dvd_mag;
          r_dvs      <= w_dvs_mag;
          r_cnt      <= CW'(WIDTH - 1);
          r_qneg     <= bus.sign_mode & (bus.dividend[WIDTH-1] ^ bus.divisor[WIDTH-1]);
          r_rneg     <= bus.sign_mode & bus.dividend[WIDTH-1];
          r_div_zero <= 1'b0;
        end
      end

      if (w_iter) begin
        r_rem <= w_ge ? w_diff : w_shift[WIDTH-1:0];
        r_quo <= {r_quo[WIDTH-2:0], w_ge};
        r_cnt <= r_cnt - 1'b1;
      end

      if (w_fix) begin
        r_lo <= r_qneg ? -r_quo : r_quo;
        r_hi <= r_rneg ? -r_rem : r_rem;
      end
    end
  end

  assign bus.hi       = r_hi;
  assign bus.lo       = r_lo;
  assign bus.busy     = r_busy;
  assign bus.done     = r_done;
  assign bus.div_zero = r_div_zero;
endmodule

// File: tb/tb_div_unit.sv
// Bench for div_unit: a transaction-level reference (64-bit arithmetic plus
// cycle ages since start) is compared with the DUT every cycle, plus literal checks.
module tb_div_unit;
  localparam int W = 32;

  logic clock;
  logic reset_n;
  int   n_checks = 0;
  int   n_fail   = 0;
  bit   chk_en   = 0;

  div_unit_if #(.WIDTH(W)) bus ();

  div_unit #(.WIDTH(W)) dut (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (bus.slave)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Returns {remainder, quotient} with truncation toward zero.
  function automatic logic [2*W-1:0] ref_div(input logic sm, input logic [W-1:0] a,
                                              input logic [W-1:0] b);
    longint sa, sb, lq, lr;
    if (sm) begin
      sa = longint'($signed(a));
      sb = longint'($signed(b));
    end else begin
      sa = longint'({32'b0, a});
      sb = longint'({32'b0, b});
    end
    lq = sa / sb;
    lr = sa % sb;
    return {lr[W-1:0], lq[W-1:0]};
  endfunction

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  // Reference model: state after each edge, expressed as age since the accepted start.
  logic           m_busy, m_done, m_dz, m_zero;
  logic [W-1:0]   m_hi, m_lo;
  logic [2*W-1:0] m_res;
  int             m_age;
  int             m_len;

  assign m_len = m_zero ? 1 : W + 2;

  always @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      m_busy <= 0; m_done <= 0; m_dz <= 0; m_zero <= 0;
      m_hi <= '0; m_lo <= '0; m_res <= '0; m_age <= 0;
    end else if (!m_busy) begin
      m_done <= 0;
      if (bus.start) begin
        m_busy <= 1;
        m_age  <= 0;
        m_zero <= (bus.divisor == '0);
        if (bus.divisor != '0) begin
          m_dz  <= 0;
          m_res <= ref_div(bus.sign_mode, bus.dividend, bus.divisor);
        end
      end
    end else begin
      m_age  <= m_age + 1;
      m_done <= (m_age + 1 == m_len);
      if (!m_zero && m_age + 1 == W + 1) {m_hi, m_lo} <= m_res;
      if (m_zero && m_age + 1 == 1) m_dz <= 1;
      if (m_age + 1 == m_len + 1) m_busy <= 0;
    end
  end

  always @(negedge clock) begin
    if (chk_en) begin
      check("cyc_busy", W'(bus.busy), W'(m_busy));
      check("cyc_done", W'(bus.done), W'(m_done));
      check("cyc_div_zero", W'(bus.div_zero), W'(m_dz));
      check("cyc_hi", bus.hi, m_hi);
      check("cyc_lo", bus.lo, m_lo);
    end
  end

  // Launches one operation from a negedge and returns edges from start to done.
  task automatic do_op(input logic sm, input logic [W-1:0] a, input logic [W-1:0] b,
                       input bit poke, output int lat);
    @(negedge clock);
    bus.start = 1; bus.sign_mode = sm; bus.dividend = a; bus.divisor = b;
    @(negedge clock);
    bus.start = 0; bus.sign_mode = 1'($urandom); bus.dividend = $urandom; bus.divisor = $urandom;
    lat = 0;
    while (!bus.done && lat < 100) begin
      @(negedge clock);
      lat++;
      if (poke && lat == 5) begin
        bus.start = 1; bus.sign_mode = ~sm; bus.dividend = $urandom; bus.divisor = 32'd3;
      end
      if (poke && lat == 6) bus.start = 0;
    end
    bus.start = 0;
    if (lat >= 100) check("done_timeout", 32'd0, 32'd1);
    check("latency", W'(lat), (b == '0) ? 32'd1 : 32'(W + 2));
    @(negedge clock);
    check("done_fall", W'(bus.done), 32'd0);
    check("busy_fall", W'(bus.busy), 32'd0);
  endtask

  int lat;

  initial begin
    reset_n = 0;
    bus.start = 0; bus.sign_mode = 0; bus.dividend = '0; bus.divisor = '0;
    repeat (2) @(negedge clock);
    check("rst_hi", bus.hi, 32'd0);
    check("rst_busy", W'(bus.busy), 32'd0);
    reset_n = 1;
    chk_en = 1;

    do_op(0, 32'd100, 32'd7, 0, lat);
    check("divu_100_7_lo", bus.lo, 32'd14);
    check("divu_100_7_hi", bus.hi, 32'd2);
    check("divu_100_7_dz", W'(bus.div_zero), 32'd0);

    do_op(1, -32'sd7, 32'd2, 0, lat);
    check("div_m7_2_lo", bus.lo, 32'hFFFF_FFFD);
    check("div_m7_2_hi", bus.hi, 32'hFFFF_FFFF);

    do_op(1, 32'd7, -32'sd2, 0, lat);
    check("div_7_m2_lo", bus.lo, 32'hFFFF_FFFD);
    check("div_7_m2_hi", bus.hi, 32'd1);

    do_op(1, 32'h8000_0000, 32'hFFFF_FFFF, 0, lat);
    check("div_ovf_lo", bus.lo, 32'h8000_0000);
    check("div_ovf_hi", bus.hi, 32'd0);

    do_op(0, 32'hFFFF_FFFF, 32'd1, 0, lat);
    check("divu_max_lo", bus.lo, 32'hFFFF_FFFF);
    check("divu_max_hi", bus.hi, 32'd0);

    do_op(0, 32'd95, 32'd10, 0, lat);
    check("pre_lo", bus.lo, 32'd9);
    check("pre_hi", bus.hi, 32'd5);
    do_op(1, 32'd1234, 32'd0, 0, lat);
    check("dz_flag", W'(bus.div_zero), 32'd1);
    check("dz_lo", bus.lo, 32'd9);
    check("dz_hi", bus.hi, 32'd5);

    do_op(0, 32'd1000, 32'd3, 1, lat);
    check("poke_lo", bus.lo, 32'd333);
    check("poke_hi", bus.hi, 32'd1);

    // Abort mid-run with an asynchronous reset.
    @(negedge clock);
    bus.start = 1; bus.sign_mode = 0; bus.dividend = 32'd12345; bus.divisor = 32'd6;
    @(negedge clock);
    bus.start = 0;
    repeat (9) @(negedge clock);
    @(posedge clock);
    #1 reset_n = 0;
    #1;
    check("arst_hi", bus.hi, 32'd0);
    check("arst_lo", bus.lo, 32'd0);
    check("arst_busy", W'(bus.busy), 32'd0);
    check("arst_done", W'(bus.done), 32'd0);
    check("arst_dz", W'(bus.div_zero), 32'd0);
    repeat (2) @(negedge clock);
    reset_n = 1;

    do_op(0, 32'd50, 32'd5, 0, lat);
    check("post_rst_lo", bus.lo, 32'd10);
    check("post_rst_hi", bus.hi, 32'd0);

    // start held high: the second operation follows once done has fallen.
    @(negedge clock);
    bus.start = 1; bus.sign_mode = 0; bus.dividend = 32'd77; bus.divisor = 32'd8;
    lat = 0;
    while (!bus.done && lat < 100) begin @(negedge clock); lat++; end
    check("held_lo1", bus.lo, 32'd9);
    bus.dividend = 32'd200; bus.divisor = 32'd9;
    lat = 0;
    do begin @(negedge clock); lat++; end while (!bus.done && lat < 100);
    bus.start = 0;
    check("held_gap", W'(lat), 32'(W + 4));
    check("held_lo2", bus.lo, 32'd22);
    check("held_hi2", bus.hi, 32'd2);
    @(negedge clock);

    for (int i = 0; i < 40; i++) begin
      logic [W-1:0] a, b;
      int sel;
      sel = $urandom_range(0, 7);
      a = $urandom;
      case (sel)
        0: b = '0;
        1: b = W'($urandom_range(1, 15));
        2: begin a = 32'h8000_0000; b = ($urandom_range(0, 1) == 1) ? 32'hFFFF_FFFF : 32'd1; end
        default: b = $urandom;
      endcase
      do_op(1'($urandom), a, b, ($urandom_range(0, 3) == 0), lat);
      repeat ($urandom_range(0, 3)) @(negedge clock);
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule
